// File: rtl/control_sequencer_if.sv
// Control-to-datapath strobe bundle: the sequencer drives every select and enable,
// the datapath returns its instruction register and the run request.
interface control_sequencer_if;
  logic        run;
  logic [31:0] IR;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic        read;
  logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
  logic        halted;
  logic        illegal;

  modport master (
    input  run, IR,
    output Rin, Rout,
    output PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    output read,
    output AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
    output halted, illegal
  );

  modport slave (
    output run, IR,
    input  Rin, Rout,
    input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
    input  read,
    input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
    input  halted, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore T-state control unit: fetch, then register-register ALU execute.
// run is a plain level request sampled only in IDLE; there is no valid/ready back-pressure.
module control_sequencer #(
  parameter int MEM_WAIT      = 0,
  parameter int MULDIV_CYCLES = 1
) (
  input  logic                clk,
  input  logic                clear,
  control_sequencer_if.master bus,
  output logic [3:0]          dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_W    = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam int         W_LOAD_I = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;
  localparam logic [3:0] W_LOAD   = 4'(W_LOAD_I);
  localparam logic [5:0] MD_LAST  = 6'(MULDIV_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] wait_cnt, wait_cnt_n;
  logic [5:0] md_cnt, md_cnt_n;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_binop, is_unary, is_muldiv, is_nop, is_halt;
  logic       do_op;
  logic       unused_ir;

  assign op        = bus.IR[31:27];
  assign ra        = bus.IR[26:23];
  assign rb        = bus.IR[22:19];
  assign rc        = bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];
  assign dbg_state = state;

  always_comb begin
    is_binop  = 1'b0;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    is_nop    = 1'b0;
    is_halt   = 1'b0;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: is_binop  = 1'b1;
      5'b01111, 5'b10000:                     is_muldiv = 1'b1;
      5'b10001, 5'b10010:                     is_unary  = 1'b1;
      5'b11010:                               is_nop    = 1'b1;
      5'b11011:                               is_halt   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      md_cnt   <= 6'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      md_cnt   <= md_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    wait_cnt_n   = wait_cnt;
    md_cnt_n     = md_cnt;
    do_op        = 1'b0;
    bus.Rin      = 16'h0000;
    bus.Rout     = 16'h0000;
    bus.PCout    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.HIout    = 1'b0;
    bus.LOout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.IRin     = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.read     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.halted   = 1'b0;
    bus.illegal  = 1'b0;

    case (state)
      S_IDLE: if (bus.run) state_n = S_T0;
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_n   = S_T1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.read    = 1'b1;
        bus.MDRin   = 1'b1;
        if (MEM_WAIT > 0) begin
          state_n    = S_W;
          wait_cnt_n = W_LOAD;
        end else begin
          state_n = S_T2;
        end
      end
      S_W: begin
        bus.read  = 1'b1;
        bus.MDRin = 1'b1;
        if (wait_cnt == 4'd0) state_n = S_T2;
        else                  wait_cnt_n = wait_cnt - 4'd1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_n    = S_T3;
      end
      S_T3: begin
        if (is_unary) begin
          bus.Rout = 16'h0001 << rb;
          do_op    = 1'b1;
          bus.Zin  = 1'b1;
          state_n  = S_T5;
        end else if (is_binop || is_muldiv) begin
          bus.Rout = 16'h0001 << rb;
          bus.Yin  = 1'b1;
          md_cnt_n = 6'd0;
          state_n  = S_T4;
        end else if (is_nop) begin
          state_n = S_T0;
        end else if (is_halt) begin
          state_n = S_HALT;
        end else begin
          bus.illegal = 1'b1;
          state_n     = S_T0;
        end
      end
      S_T4: begin
        bus.Rout = 16'h0001 << rc;
        do_op    = 1'b1;
        // Multi-cycle ops hold their strobe; the result is latched only on the final cycle.
        if (is_muldiv) begin
          if (md_cnt >= MD_LAST) begin
            bus.Zin = 1'b1;
            state_n = S_T5;
          end else begin
            md_cnt_n = md_cnt + 6'd1;
          end
        end else begin
          bus.Zin = 1'b1;
          state_n = S_T5;
        end
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_muldiv) begin
          bus.LOin = 1'b1;
          state_n  = S_T6;
        end else begin
          bus.Rin = 16'h0001 << ra;
          state_n = S_T0;
        end
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        state_n      = S_T0;
      end
      S_HALT: bus.halted = 1'b1;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.AND = 1'b0;
    bus.OR  = 1'b0;
    bus.ADD = 1'b0;
    bus.SUB = 1'b0;
    bus.MUL = 1'b0;
    bus.DIV = 1'b0;
    bus.SHR = 1'b0;
    bus.SHL = 1'b0;
    bus.ROR = 1'b0;
    bus.ROL = 1'b0;
    bus.NEG = 1'b0;
    bus.NOT = 1'b0;
    if (do_op) begin
      case (op)
        5'b00011: bus.ADD = 1'b1;
        5'b00100: bus.SUB = 1'b1;
        5'b00101: bus.AND = 1'b1;
        5'b00110: bus.OR  = 1'b1;
        5'b00111: bus.SHR = 1'b1;
        5'b01000: bus.SHL = 1'b1;
        5'b01001: bus.ROR = 1'b1;
        5'b01010: bus.ROL = 1'b1;
        5'b01111: bus.MUL = 1'b1;
        5'b10000: bus.DIV = 1'b1;
        5'b10001: bus.NEG = 1'b1;
        5'b10010: bus.NOT = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
